// File: rtl/ser2par_pkg.sv
// ser2par_pkg: shared state encoding, default sizes and index-width helper for ser2par_stream.
package ser2par_pkg;
  typedef enum logic {ST_RUN, ST_HUNT} state_t;
  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ser2par_fifo.sv
// ser2par_fifo: synchronous word FIFO; a push into a full FIFO is taken only alongside a pop.
module ser2par_fifo
  import ser2par_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int PW = idx_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic          w_push, w_pop;
  assign o_empty = r_level == '0;
  assign o_full  = r_level == LW'(DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_level = r_level;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/ser2par_stream.sv
// ser2par_stream: qualified serial-to-parallel deserialiser with framing checks, resync and output FIFO.
module ser2par_stream
  import ser2par_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          serial_in,
  input  logic                          lsb_in,
  input  logic                          msb_first,
  output logic [WORD_SIZE-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overflow
);
  localparam int CW = idx_w(WORD_SIZE);
  localparam logic [CW-1:0] LAST = CW'(WORD_SIZE - 1);
  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [WORD_SIZE-1:0] r_shift, w_shift_nxt;
  logic                 r_msb, r_frame_err, r_overflow;
  logic                 w_mode, w_push, w_ferr, w_full, w_empty;
  // Mode comes straight from the pin on a word's first bit, then from the latch.
  assign w_mode      = (r_cnt == '0) ? msb_first : r_msb;
  assign w_shift_nxt = w_mode ? {r_shift[WORD_SIZE-2:0], serial_in}
                              : {serial_in, r_shift[WORD_SIZE-1:1]};
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    if (in_valid) begin
      if (r_state == ST_HUNT) begin
        w_state_nxt = lsb_in ? ST_RUN : ST_HUNT;
      end else if (lsb_in) begin
        w_cnt_nxt = '0;
        w_push    = r_cnt == LAST;
        w_ferr    = r_cnt != LAST;
      end else if (r_cnt == LAST) begin
        w_cnt_nxt   = '0;
        w_ferr      = 1'b1;
        w_state_nxt = ST_HUNT;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_msb       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_frame_err <= w_ferr;
      r_overflow  <= w_push & w_full & ~(out_ready & ~w_empty);
      if (in_valid && r_state == ST_RUN) begin
        r_shift <= w_shift_nxt;
        if (r_cnt == '0) r_msb <= msb_first;
      end
    end
  end
  ser2par_fifo #(.W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .i_push (w_push),
    .i_pop  (out_ready),
    .i_data (w_shift_nxt),
    .o_data (out_data),
    .o_level(fifo_level),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign out_valid = ~w_empty;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_ser2par_stream.sv
// tb_ser2par_stream: directed scenario tasks with hand-computed expectations for ser2par_stream.
module tb_ser2par_stream;
  logic       clk = 0, reset = 0, in_valid = 0, serial_in = 0, lsb_in = 0, msb_first = 1, out_ready = 0;
  logic [7:0] out_data;
  logic [2:0] fifo_level;
  logic       out_valid, frame_err, overflow;
  int total = 0, bad = 0, n_ferr = 0, n_ovf = 0;

  ser2par_stream #(.WORD_SIZE(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .serial_in(serial_in), .lsb_in(lsb_in),
    .msb_first(msb_first), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overflow) n_ovf++;
  end

  task automatic send_bit(input logic b, input logic l);
    serial_in = b; lsb_in = l; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; lsb_in = 0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic m);
    msb_first = m;
    for (int i = 0; i < 8; i++) send_bit(m ? w[7-i] : w[i], i == 7);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 0; #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", out_data); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b exp=0", frame_err); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first();
    logic [6:0] b = 7'b0001001;
    n_ferr = 0; n_ovf = 0; out_ready = 1; msb_first = 1;
    for (int i = 6; i >= 0; i--) send_bit(b[i], 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b exp=0", out_valid); end
    send_bit(1, 1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'h13) begin bad++; $display("FAIL t1_data got=%h exp=13", out_data); end
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL t1_level got=%0d exp=1", fifo_level); end
    idle(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_popped got=%b exp=0", out_valid); end
    total++; if (n_ferr !== 0 || n_ovf !== 0) begin bad++; $display("FAIL t1_pulses got=%0d/%0d exp=0/0", n_ferr, n_ovf); end
    out_ready = 0;
  endtask

  task automatic test_lsb_gap();
    logic [7:0] b = 8'b1010_0101;
    n_ferr = 0; msb_first = 0;
    for (int i = 7; i >= 4; i--) send_bit(b[i], 0);
    msb_first = 1;
    idle(3);
    for (int i = 3; i >= 0; i--) send_bit(b[i], i == 0);
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL t2_data got=%h exp=a5", out_data); end
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL t2_level got=%0d exp=1", fifo_level); end
    idle(1);
    total++; if (n_ferr !== 0) begin bad++; $display("FAIL t2_ferr got=%0d exp=0", n_ferr); end
    pop_one();
  endtask

  task automatic test_early_marker();
    n_ferr = 0; msb_first = 1;
    for (int i = 0; i < 4; i++) send_bit(1, 0);
    send_bit(1, 1);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL t3_ferr got=%b exp=1", frame_err); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL t3_nopush got=%0d exp=0", fifo_level); end
    idle(1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL t3_ferr_end got=%b exp=0", frame_err); end
    send_word(8'h26, 1);
    total++; if (out_data !== 8'h26 || fifo_level !== 3'd1) begin bad++; $display("FAIL t3_word got=%h/%0d exp=26/1", out_data, fifo_level); end
    idle(1);
    total++; if (n_ferr !== 1) begin bad++; $display("FAIL t3_nferr got=%0d exp=1", n_ferr); end
    pop_one();
  endtask

  task automatic test_missing_marker();
    n_ferr = 0; msb_first = 1;
    for (int i = 0; i < 8; i++) send_bit(1, 0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL t4_ferr got=%b exp=1", frame_err); end
    send_bit(1, 0);
    send_bit(1, 0);
    send_bit(0, 1);
    total++; if (frame_err !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL t4_hunt got=%b/%0d exp=0/0", frame_err, fifo_level); end
    send_word(8'h39, 1);
    total++; if (out_data !== 8'h39 || fifo_level !== 3'd1) begin bad++; $display("FAIL t4_word got=%h/%0d exp=39/1", out_data, fifo_level); end
    idle(1);
    total++; if (n_ferr !== 1) begin bad++; $display("FAIL t4_nferr got=%0d exp=1", n_ferr); end
    pop_one();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t4_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] w[5] = '{8'h00, 8'h13, 8'h26, 8'h39, 8'h4C};
    n_ovf = 0;
    for (int i = 0; i < 4; i++) send_word(w[i], 1);
    total++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL t5_full got=%0d/%b exp=4/0", fifo_level, overflow); end
    send_word(w[4], 1);
    total++; if (overflow !== 1'b1 || fifo_level !== 3'd4) begin bad++; $display("FAIL t5_ovf got=%b/%0d exp=1/4", overflow, fifo_level); end
    idle(1);
    total++; if (overflow !== 1'b0 || n_ovf !== 1) begin bad++; $display("FAIL t5_pulse got=%b/%0d exp=0/1", overflow, n_ovf); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== w[i]) begin bad++; $display("FAIL t5_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_data, w[i]); end
      pop_one();
    end
    total++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL t5_empty got=%b/%0d exp=0/0", out_valid, fifo_level); end
  endtask

  task automatic test_full_pop();
    logic [7:0] w[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    n_ovf = 0; msb_first = 1;
    for (int i = 0; i < 4; i++) send_word(w[i], 1);
    for (int i = 7; i >= 1; i--) send_bit(w[4][i], 0);
    out_ready = 1;
    send_bit(w[4][0], 1);
    out_ready = 0;
    total++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL t7_level got=%0d/%b exp=4/0", fifo_level, overflow); end
    total++; if (out_data !== 8'h22) begin bad++; $display("FAIL t7_head got=%h exp=22", out_data); end
    for (int i = 1; i < 5; i++) begin
      total++; if (out_data !== w[i]) begin bad++; $display("FAIL t7_drain%0d got=%h exp=%h", i, out_data, w[i]); end
      pop_one();
    end
    total++; if (out_valid !== 1'b0 || n_ovf !== 0) begin bad++; $display("FAIL t7_end got=%b/%0d exp=0/0", out_valid, n_ovf); end
  endtask

  task automatic test_reset_midword();
    send_word(8'h01, 1);
    send_word(8'h02, 1);
    for (int i = 0; i < 3; i++) send_bit(1, 0);
    #2; reset = 0; #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL t6_out got=%b/%h exp=0/00", out_valid, out_data); end
    total++; if (fifo_level !== 3'd0 || frame_err !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL t6_state got=%0d/%b/%b exp=0/0/0", fifo_level, frame_err, overflow); end
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    n_ferr = 0; n_ovf = 0;
    send_word(8'h5F, 1);
    total++; if (out_data !== 8'h5F || fifo_level !== 3'd1) begin bad++; $display("FAIL t6_word got=%h/%0d exp=5f/1", out_data, fifo_level); end
    pop_one();
    total++; if (out_valid !== 1'b0 || n_ferr !== 0 || n_ovf !== 0) begin bad++; $display("FAIL t6_end got=%b/%0d/%0d exp=0/0/0", out_valid, n_ferr, n_ovf); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_gap();
    test_early_marker();
    test_missing_marker();
    test_overflow();
    test_full_pop();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
